serdesphy_pcs_tx: RTL and testbench

Parametrised PCS transmit datapath in the 240 MHz TX domain. It buffers DATA_W-bit words from the protocol side in a single-clock FIFO and selects per word between FIFO data, an idle word and a PRBS7 test word. It serialises MSB-first onto the PMA serial interface and drives the TX status flags consumed by the CSR block. It replaces the tied-off TX status defaults in serdesphy_pcs.

---
 rtl/serdesphy_pcs_pkg.sv | 23 ++
 rtl/serdesphy_sync_fifo.sv | 71 +++++++
 rtl/serdesphy_pcs_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_serdesphy_pcs_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_pcs_pkg.sv
// Shared constants and types for the SERDES PHY PCS transmit path.
// Holds engine state encoding, PRBS7 seed/taps and the default idle word.
// No logic; imported by the PCS TX top and its sub-modules.
package serdesphy_pcs_pkg;

    // Engine state encoding (one bit, kept as plain constants for older tools)
    localparam logic [0:0] ST_OFF = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;

    typedef enum logic [0:0] {
        ENG_OFF = ST_OFF,
        ENG_RUN = ST_RUN
    } eng_state_e;

    // PRBS7, x^7 + x^6 + 1: feedback is s[6] ^ s[5], output bit is s[6]
    localparam logic [6:0] PRBS7_SEED  = 7'h7F;
    localparam int         PRBS7_TAP_A = 6;
    localparam int         PRBS7_TAP_B = 5;

    // Idle word, zero-extended (or truncated) to the datapath width by the user
    localparam logic [3:0] IDLE_WORD_DEF = 4'b1010;

endpackage

// File: rtl/serdesphy_sync_fifo.sv
// Single-clock FIFO with synchronous flush.
// Latency: a pushed word is visible at dout/empty after one edge.
// Backpressure: push is dropped when full unless a pop happens on the same edge.
//
// Ports: clk, rst_n (async active-low), flush (empties on next edge),
//        push/din (write), pop (read head), dout (head word),
//        full/empty (level flags derived from the registered count).
module serdesphy_sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; contents are qualified by the count
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/serdesphy_pcs_tx.sv
// PCS TX: buffers protocol words, picks FIFO/idle/PRBS7 per word, serialises MSB-first.
// Latency: first bit on the edge tx_en is sampled high; FIFO word eligible one edge after write.
// Backpressure: tx_ready = !full && tx_fifo_en; writes into a full FIFO set sticky tx_overflow.
//
// Ports: clk_240m_tx / rst_n_240m_tx (async active-low); control tx_en, tx_fifo_en,
//        tx_prbs_en, tx_idle, tx_data_sel, sticky_clr; write side tx_data/tx_valid/tx_ready;
//        serial side tx_serial_data/tx_serial_valid; status tx_idle_pattern, tx_fifo_full,
//        tx_fifo_empty, tx_overflow, tx_underflow, tx_active, tx_error.
// Build option: SERDESPHY_PCS_TX_PRBS_EN adds the PRBS7 generator and PRBS source select;
//        without it tx_prbs_en and tx_data_sel have no effect.
module serdesphy_pcs_tx
    import serdesphy_pcs_pkg::*;
#(
    parameter int                DATA_W     = 4,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [DATA_W-1:0] IDLE_WORD  = DATA_W'(IDLE_WORD_DEF)
) (
    input  logic              clk_240m_tx,
    input  logic              rst_n_240m_tx,
    input  logic              tx_en,
    input  logic              tx_fifo_en,
    input  logic              tx_prbs_en,
    input  logic              tx_idle,
    input  logic              tx_data_sel,
    input  logic              sticky_clr,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial_data,
    output logic              tx_serial_valid,
    output logic              tx_idle_pattern,
    output logic              tx_fifo_full,
    output logic              tx_fifo_empty,
    output logic              tx_overflow,
    output logic              tx_underflow,
    output logic              tx_active,
    output logic              tx_error
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    logic [0:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_q;
    logic              ser_vld_q;
    logic              idle_pat_q;
    logic              active_q;
    logic              ovf_q;
    logic              udf_q;

    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    logic              load;
    logic [DATA_W-1:0] load_word;
    logic              load_idle;
    logic              udf_set;
    logic              ovf_set;

    // ------------------------------------------------------------------
    // Input FIFO; a low tx_fifo_en flushes it and blocks writes
    // ------------------------------------------------------------------
    assign fifo_push = tx_valid && tx_fifo_en && (!fifo_full || fifo_pop);
    assign ovf_set   = tx_valid && tx_fifo_en && fifo_full && !fifo_pop;

    serdesphy_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_240m_tx),
        .rst_n (rst_n_240m_tx),
        .flush (!tx_fifo_en),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A word is loaded on the enable edge and on every counter wrap
    assign load = tx_en && ((state == ST_OFF) || (bit_cnt == CNT_LAST));

`ifdef SERDESPHY_PCS_TX_PRBS_EN
    // ------------------------------------------------------------------
    // PRBS7: a whole word of DATA_W steps is produced per load
    // ------------------------------------------------------------------
    logic [6:0]        prbs_q;
    logic [6:0]        prbs_next;
    logic [DATA_W-1:0] prbs_word;
    logic              prbs_step;

    always_comb begin
        logic [6:0] s;
        s         = prbs_q;
        prbs_word = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            prbs_word[i] = s[6];
            s = {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
        end
        prbs_next = s;
    end

    always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
        if (!rst_n_240m_tx) begin
            prbs_q <= PRBS7_SEED;
        end else if (!tx_prbs_en) begin
            prbs_q <= PRBS7_SEED;
        end else if (prbs_step) begin
            prbs_q <= prbs_next;
        end
    end
`else
    logic unused_prbs_ctrl;
    assign unused_prbs_ctrl = tx_prbs_en ^ tx_data_sel;
`endif

    // ------------------------------------------------------------------
    // Load source selection: idle > PRBS > FIFO > idle (underrun)
    // The FIFO is sampled from registered flags, so a push on the load
    // edge of an empty FIFO is not bypassed to the serialiser.
    // ------------------------------------------------------------------
    always_comb begin
        load_word = IDLE_WORD;
        load_idle = 1'b1;
        fifo_pop  = 1'b0;
        udf_set   = 1'b0;
`ifdef SERDESPHY_PCS_TX_PRBS_EN
        prbs_step = 1'b0;
`endif
        if (load) begin
            if (tx_idle) begin
                load_word = IDLE_WORD;
            end
`ifdef SERDESPHY_PCS_TX_PRBS_EN
            else if (tx_data_sel) begin
                // A stopped generator falls back to the idle word
                if (tx_prbs_en) begin
                    load_word = prbs_word;
                    load_idle = 1'b0;
                    prbs_step = 1'b1;
                end
            end
`endif
            else if (!fifo_empty) begin
                load_word = fifo_dout;
                load_idle = 1'b0;
                fifo_pop  = 1'b1;
            end else begin
                // Running dry only counts as an underrun once real data has flowed
                udf_set = active_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser engine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
        if (!rst_n_240m_tx) begin
            state      <= ST_OFF;
            bit_cnt    <= '0;
            shift_q    <= '0;
            ser_vld_q  <= 1'b0;
            idle_pat_q <= 1'b0;
        end else if (load) begin
            state      <= ST_RUN;
            bit_cnt    <= '0;
            shift_q    <= load_word;
            ser_vld_q  <= 1'b1;
            idle_pat_q <= load_idle;
        end else if (state == ST_RUN) begin
            if (!tx_en) begin
                // Abort: partial word is discarded, FIFO untouched
                state      <= ST_OFF;
                bit_cnt    <= '0;
                shift_q    <= '0;
                ser_vld_q  <= 1'b0;
                idle_pat_q <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                shift_q <= {shift_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------
    // Status: tx_active drops whenever the engine is (or goes) off;
    // sticky flags give priority to a set over a clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
        if (!rst_n_240m_tx) begin
            active_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (!tx_en) begin
                active_q <= 1'b0;
            end else if (fifo_pop) begin
                active_q <= 1'b1;
            end
            ovf_q <= ovf_set | (ovf_q & !sticky_clr);
            udf_q <= udf_set | (udf_q & !sticky_clr);
        end
    end

    assign tx_ready        = !fifo_full && tx_fifo_en;
    assign tx_serial_data  = shift_q[DATA_W-1];
    assign tx_serial_valid = ser_vld_q;
    assign tx_idle_pattern = idle_pat_q;
    assign tx_fifo_full    = fifo_full;
    assign tx_fifo_empty   = fifo_empty;
    assign tx_overflow     = ovf_q;
    assign tx_underflow    = udf_q;
    assign tx_active       = active_q;
    assign tx_error        = ovf_q | udf_q;

endmodule

// File: tb/tb_serdesphy_pcs_tx.sv
// Directed bench for serdesphy_pcs_tx (DATA_W=4, FIFO_DEPTH=8, IDLE_WORD=4'hA).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
// Expected serial bit streams and flag values are hand-computed constants.
`timescale 1ns/1ps
module tb_serdesphy_pcs_tx;

    logic       clk_240m_tx = 1'b0;
    logic       rst_n_240m_tx;
    logic       tx_en, tx_fifo_en, tx_prbs_en, tx_idle, tx_data_sel, sticky_clr;
    logic [3:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_serial_data, tx_serial_valid, tx_idle_pattern;
    logic       tx_fifo_full, tx_fifo_empty, tx_overflow, tx_underflow, tx_active, tx_error;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_bits;
    logic [3:0] exp_word;

    always #2 clk_240m_tx = ~clk_240m_tx;

    serdesphy_pcs_tx #(
        .DATA_W     (4),
        .FIFO_DEPTH (8),
        .IDLE_WORD  (4'b1010)
    ) dut (
        .clk_240m_tx     (clk_240m_tx),
        .rst_n_240m_tx   (rst_n_240m_tx),
        .tx_en           (tx_en),
        .tx_fifo_en      (tx_fifo_en),
        .tx_prbs_en      (tx_prbs_en),
        .tx_idle         (tx_idle),
        .tx_data_sel     (tx_data_sel),
        .sticky_clr      (sticky_clr),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_serial_data  (tx_serial_data),
        .tx_serial_valid (tx_serial_valid),
        .tx_idle_pattern (tx_idle_pattern),
        .tx_fifo_full    (tx_fifo_full),
        .tx_fifo_empty   (tx_fifo_empty),
        .tx_overflow     (tx_overflow),
        .tx_underflow    (tx_underflow),
        .tx_active       (tx_active),
        .tx_error        (tx_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_240m_tx);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"},     tx_ready, 0);
        check({tag, "_sdata"},     tx_serial_data, 0);
        check({tag, "_svalid"},    tx_serial_valid, 0);
        check({tag, "_idlepat"},   tx_idle_pattern, 0);
        check({tag, "_full"},      tx_fifo_full, 0);
        check({tag, "_empty"},     tx_fifo_empty, 1);
        check({tag, "_overflow"},  tx_overflow, 0);
        check({tag, "_underflow"}, tx_underflow, 0);
        check({tag, "_active"},    tx_active, 0);
        check({tag, "_error"},     tx_error, 0);
    endtask

    initial begin
        rst_n_240m_tx = 1'b0;
        tx_en = 0; tx_fifo_en = 0; tx_prbs_en = 0; tx_idle = 0;
        tx_data_sel = 0; sticky_clr = 0; tx_data = 4'h0; tx_valid = 0;
        #1;
        check_reset_state("por");
        tick();
        rst_n_240m_tx = 1'b1;
        tick();

        // ---------------- FIFO data path: A, 5, then idle with underrun
        tx_fifo_en = 1;
        tick();
        check("ready_empty", tx_ready, 1);
        tx_valid = 1; tx_data = 4'hA;
        tick();
        check("empty_after_push", tx_fifo_empty, 0);
        tx_data = 4'h5;
        tick();
        tx_valid = 0;
        tx_en = 1;
        tick();
        check("active_first_load", tx_active, 1);
        exp_bits = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fifo_bit%0d", i), tx_serial_data, exp_bits[7-i]);
            check($sformatf("fifo_vld%0d", i), tx_serial_valid, 1);
            if (i == 4) begin
                check("empty_after_2nd_load", tx_fifo_empty, 1);
                check("no_underflow_yet", tx_underflow, 0);
            end
            tick();
        end
        exp_word = 4'hA;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("idle_bit%0d", i), tx_serial_data, exp_word[3-i]);
            check($sformatf("idle_pat%0d", i), tx_idle_pattern, 1);
            check($sformatf("underflow%0d", i), tx_underflow, 1);
            check($sformatf("error_udf%0d", i), tx_error, 1);
            tick();
        end
        check("idle2_msb", tx_serial_data, 1);

        // ---------------- Reset mid-word, no clock edge
        tx_fifo_en = 0;
        rst_n_240m_tx = 1'b0;
        #1;
        check_reset_state("mid_rst");
        tx_en = 0;
        rst_n_240m_tx = 1'b1;
        tick();
        tx_fifo_en = 1;
        tick();

        // ---------------- Overflow with tx_en low
        for (int i = 1; i <= 8; i++) begin
            tx_valid = 1; tx_data = 4'(i);
            tick();
            check($sformatf("full_after_%0d", i), tx_fifo_full, (i == 8) ? 1 : 0);
        end
        check("ready_when_full", tx_ready, 0);
        check("ovf_before_9th", tx_overflow, 0);
        tx_data = 4'h9;
        tick();
        check("ovf_9th", tx_overflow, 1);
        check("err_9th", tx_error, 1);
        tx_valid = 0; sticky_clr = 1;
        tick();
        check("ovf_cleared", tx_overflow, 0);
        check("err_cleared", tx_error, 0);
        check("full_kept", tx_fifo_full, 1);
        tx_valid = 1;
        tick();
        check("set_beats_clr", tx_overflow, 1);
        tx_valid = 0;
        tick();
        check("ovf_cleared2", tx_overflow, 0);
        sticky_clr = 0;

        // ---------------- Full boundary: push and load on the same edge
        tx_en = 1; tx_valid = 1; tx_data = 4'hC;
        tick();
        tx_valid = 0;
        check("bnd_full", tx_fifo_full, 1);
        check("bnd_no_ovf", tx_overflow, 0);
        check("bnd_svalid", tx_serial_valid, 1);
        exp_word = 4'h1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("w1_bit%0d", i), tx_serial_data, exp_word[3-i]);
            tick();
        end
        check("w2_loaded_not_full", tx_fifo_full, 0);

        // ---------------- Abort after 2 bits of word 2, then restart
        exp_word = 4'h2;
        check("w2_bit0", tx_serial_data, exp_word[3]);
        tick();
        check("w2_bit1", tx_serial_data, exp_word[2]);
        tx_en = 0;
        tick();
        check("abort_svalid", tx_serial_valid, 0);
        check("abort_sdata", tx_serial_data, 0);
        check("abort_active", tx_active, 0);
        check("abort_not_full", tx_fifo_full, 0);
        tx_valid = 1; tx_data = 4'hD;
        tick();
        tx_valid = 0;
        check("abort_count_kept", tx_fifo_full, 1);
        tx_en = 1;
        tick();
        check("restart_not_full", tx_fifo_full, 0);
        exp_word = 4'h3;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("w3_bit%0d", i), tx_serial_data, exp_word[3-i]);
            check($sformatf("w3_vld%0d", i), tx_serial_valid, 1);
            tick();
        end
        tx_en = 0;
        tick();
        check("stop_svalid", tx_serial_valid, 0);

        // ---------------- Flush; writes ignored while disabled
        tx_fifo_en = 0; tx_valid = 1; tx_data = 4'h7;
        tick();
        tx_valid = 0;
        check("flush_empty", tx_fifo_empty, 1);
        check("flush_ready", tx_ready, 0);
        check("flush_no_ovf", tx_overflow, 0);

        // ---------------- PRBS source
        tx_prbs_en = 1; tx_data_sel = 1; tx_en = 1;
        tick();
`ifdef SERDESPHY_PCS_TX_PRBS_EN
        exp_bits = 8'hFE;
        check("prbs_idlepat", tx_idle_pattern, 0);
`else
        exp_bits = 8'hAA;
        check("prbs_idlepat", tx_idle_pattern, 1);
`endif
        for (int i = 0; i < 8; i++) begin
            check($sformatf("prbs_bit%0d", i), tx_serial_data, exp_bits[7-i]);
            check($sformatf("prbs_vld%0d", i), tx_serial_valid, 1);
            tick();
        end
        check("prbs_no_udf", tx_underflow, 0);
        tx_en = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
